// File: rtl/div_issue_ctrl.sv
// Issue/sequencing controller for the multi-cycle radix-2 divider in the EX stage.
// Latches operands, runs the divider handshake, stalls EX and presents a one-shot {hi,lo} result.
module div_issue_ctrl #(
    parameter int unsigned TIMEOUT = 48,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        stallM,
    output logic        div_opn_valid,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_sign,
    output logic        div_abort,
    output logic        div_res_ready,
    input  logic        div_res_valid,
    input  logic [63:0] div_result,
    output logic        stall_e,
    output logic        hilo_valid,
    output logic [63:0] hilo_out,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ZERO = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              div_opn_valid_q, div_opn_valid_d;
    logic [31:0]       div_a_q, div_a_d;
    logic [31:0]       div_b_q, div_b_d;
    logic              div_sign_q, div_sign_d;
    logic              div_abort_q, div_abort_d;
    logic              hilo_valid_q, hilo_valid_d;
    logic [63:0]       hilo_out_q, hilo_out_d;
    logic              timeout_err_q, timeout_err_d;

    logic              b_zero_s;
    logic              res_take_s;
    logic              tmo_s;

    assign b_zero_s   = (b == 32'd0);
    assign res_take_s = div_res_valid & ~stallM;
    // A result arriving on the last allowed cycle beats the timeout.
    assign tmo_s      = (cnt_q == CNT_LAST) & ~div_res_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; flush overrides every state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = b_zero_s ? S_ZERO : S_BUSY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (res_take_s || tmo_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
                S_ZERO: state_d = S_DONE;
                S_DONE: begin
                    if (stallM) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output/datapath next values for the registered outputs
    always_comb begin
        cnt_d           = cnt_q;
        div_opn_valid_d = div_opn_valid_q;
        div_a_d         = div_a_q;
        div_b_d         = div_b_q;
        div_sign_d      = div_sign_q;
        div_abort_d     = 1'b0;
        hilo_valid_d    = hilo_valid_q;
        hilo_out_d      = hilo_out_q;
        timeout_err_d   = timeout_err_q;
        if (flush) begin
            div_opn_valid_d = 1'b0;
            hilo_valid_d    = 1'b0;
            cnt_d           = {CNT_W{1'b0}};
            div_abort_d     = (state_q == S_BUSY);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !b_zero_s) begin
                        div_a_d         = a;
                        div_b_d         = b;
                        div_sign_d      = sign;
                        div_opn_valid_d = 1'b1;
                        cnt_d           = {CNT_W{1'b0}};
                    end else begin
                        div_opn_valid_d = 1'b0;
                    end
                end
                S_BUSY: begin
                    if (res_take_s) begin
                        hilo_out_d      = div_result;
                        hilo_valid_d    = 1'b1;
                        div_opn_valid_d = 1'b0;
                    end else if (tmo_s) begin
                        div_abort_d     = 1'b1;
                        timeout_err_d   = 1'b1;
                        hilo_out_d      = 64'h0;
                        hilo_valid_d    = 1'b1;
                        div_opn_valid_d = 1'b0;
                    end else if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_ZERO: begin
                    hilo_out_d   = 64'h0;
                    hilo_valid_d = 1'b1;
                end
                S_DONE: begin
                    if (stallM) begin
                        hilo_valid_d = 1'b1;
                    end else begin
                        hilo_valid_d = 1'b0;
                    end
                end
                default: begin
                    div_opn_valid_d = 1'b0;
                    hilo_valid_d    = 1'b0;
                end
            endcase
        end
    end

    // Registered outputs and busy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q           <= {CNT_W{1'b0}};
            div_opn_valid_q <= 1'b0;
            div_a_q         <= 32'd0;
            div_b_q         <= 32'd0;
            div_sign_q      <= 1'b0;
            div_abort_q     <= 1'b0;
            hilo_valid_q    <= 1'b0;
            hilo_out_q      <= 64'h0;
            timeout_err_q   <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            div_opn_valid_q <= div_opn_valid_d;
            div_a_q         <= div_a_d;
            div_b_q         <= div_b_d;
            div_sign_q      <= div_sign_d;
            div_abort_q     <= div_abort_d;
            hilo_valid_q    <= hilo_valid_d;
            hilo_out_q      <= hilo_out_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign stall_e       = ((state_q == S_IDLE) & start & ~flush) | (state_q == S_BUSY) | (state_q == S_ZERO);
    assign div_res_ready = (state_q == S_BUSY) & ~stallM;

    assign div_opn_valid = div_opn_valid_q;
    assign div_a         = div_a_q;
    assign div_b         = div_b_q;
    assign div_sign      = div_sign_q;
    assign div_abort     = div_abort_q;
    assign hilo_valid    = hilo_valid_q;
    assign hilo_out      = hilo_out_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: a behavioural model plus a small divider responder,
// compared every cycle, with hand-computed literal expectations on key results.
module tb_div_issue_ctrl;

    localparam int TIMEOUT = 48;
    localparam int LAT     = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, sign = 1'b0, flush = 1'b0, stallM = 1'b0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        div_res_valid = 1'b0;
    logic [63:0] div_result = 64'h0;
    logic        div_opn_valid, div_sign, div_abort, div_res_ready, stall_e, hilo_valid, timeout_err;
    logic [31:0] div_a, div_b;
    logic [63:0] hilo_out;

    int n_vec = 0;
    int n_err = 0;

    div_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .sign(sign), .a(a), .b(b),
        .flush(flush), .stallM(stallM),
        .div_opn_valid(div_opn_valid), .div_a(div_a), .div_b(div_b), .div_sign(div_sign),
        .div_abort(div_abort), .div_res_ready(div_res_ready),
        .div_res_valid(div_res_valid), .div_result(div_result),
        .stall_e(stall_e), .hilo_valid(hilo_valid), .hilo_out(hilo_out), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference quotient/remainder packed as {remainder, quotient}
    function automatic logic [63:0] golden(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [31:0] xs, ys, qs, rs;
        logic [31:0] q, r;
        xs = x; ys = y;
        if (s) begin
            qs = xs / ys; rs = xs % ys;
            q = qs; r = rs;
        end else begin
            q = x / y; r = x % y;
        end
        return {r, q};
    endfunction

    // Behavioural model of the controller: which phase the instruction is in and what it owes EX
    localparam int P_IDLE = 0, P_BUSY = 1, P_ZERO = 2, P_DONE = 3;
    int          m_ph = P_IDLE;
    int          m_wait = 0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0;
    logic        m_s = 1'b0, m_opv = 1'b0, m_abort = 1'b0, m_hv = 1'b0, m_terr = 1'b0;
    logic [63:0] m_hilo = 64'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= P_IDLE; m_wait <= 0; m_a <= 32'd0; m_b <= 32'd0; m_s <= 1'b0;
            m_opv <= 1'b0; m_abort <= 1'b0; m_hv <= 1'b0; m_terr <= 1'b0; m_hilo <= 64'h0;
        end else begin
            m_abort <= 1'b0;
            if (flush) begin
                m_abort <= (m_ph == P_BUSY);
                m_ph <= P_IDLE; m_opv <= 1'b0; m_hv <= 1'b0; m_wait <= 0;
            end else if (m_ph == P_IDLE) begin
                if (start && b == 32'd0) begin
                    m_ph <= P_ZERO;
                end else if (start) begin
                    m_a <= a; m_b <= b; m_s <= sign; m_opv <= 1'b1; m_wait <= 0; m_ph <= P_BUSY;
                end
            end else if (m_ph == P_ZERO) begin
                m_hilo <= 64'h0; m_hv <= 1'b1; m_ph <= P_DONE;
            end else if (m_ph == P_BUSY) begin
                if (div_res_valid && !stallM) begin
                    m_hilo <= golden(m_a, m_b, m_s); m_hv <= 1'b1; m_opv <= 1'b0; m_ph <= P_DONE;
                end else if (!div_res_valid && m_wait >= TIMEOUT - 1) begin
                    m_abort <= 1'b1; m_terr <= 1'b1; m_hilo <= 64'h0; m_hv <= 1'b1;
                    m_opv <= 1'b0; m_ph <= P_DONE;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end else if (m_ph == P_DONE) begin
                if (!stallM) begin
                    m_hv <= 1'b0; m_ph <= P_IDLE;
                end
            end
        end
    end

    logic rsp_en = 1'b1, rsp_busy = 1'b0;
    int   rsp_cnt = 0;
    logic p_opn, p_rdy, p_abort;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, then step the divider responder after the rising edge
    task automatic tick();
        logic exp_stall, exp_rdy;
        @(negedge clk);
        exp_stall = (m_ph == P_IDLE && start && !flush) || m_ph == P_BUSY || m_ph == P_ZERO;
        exp_rdy   = (m_ph == P_BUSY) && !stallM;
        chk("stall_e", 64'(stall_e), 64'(exp_stall));
        chk("div_res_ready", 64'(div_res_ready), 64'(exp_rdy));
        chk("div_opn_valid", 64'(div_opn_valid), 64'(m_opv));
        chk("div_abort", 64'(div_abort), 64'(m_abort));
        chk("hilo_valid", 64'(hilo_valid), 64'(m_hv));
        chk("timeout_err", 64'(timeout_err), 64'(m_terr));
        if (m_hv) chk("hilo_out", hilo_out, m_hilo);
        if (m_opv) begin
            chk("div_a", 64'(div_a), 64'(m_a));
            chk("div_b", 64'(div_b), 64'(m_b));
            chk("div_sign", 64'(div_sign), 64'(m_s));
        end
        p_opn = div_opn_valid; p_rdy = div_res_ready; p_abort = div_abort;
        @(posedge clk);
        #1;
        if (rst || p_abort) begin
            rsp_busy = 1'b0; div_res_valid = 1'b0;
        end else if (div_res_valid) begin
            if (p_rdy) div_res_valid = 1'b0;
        end else if (rsp_busy) begin
            if (rsp_cnt == 0) begin
                div_res_valid = 1'b1; div_result = golden(div_a, div_b, div_sign); rsp_busy = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end else if (p_opn && rsp_en) begin
            rsp_busy = 1'b1; rsp_cnt = LAT;
        end
    endtask

    task automatic launch(input logic s, input logic [31:0] x, input logic [31:0] y);
        sign = s; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    endtask

    task automatic wait_hv(input string nm);
        for (int i = 0; i < 80; i++) begin
            if (hilo_valid) break;
            tick();
        end
        chk(nm, 64'(hilo_valid), 64'd1);
    endtask

    initial begin
        tick(); tick();
        chk("rst_hilo_out", hilo_out, 64'h0);
        chk("rst_opn_valid", 64'(div_opn_valid), 64'd0);
        rst = 1'b0;
        tick();

        // DIVU 100/7
        launch(1'b0, 32'd100, 32'd7);
        wait_hv("t1_wait");
        chk("t1_hilo", hilo_out, 64'h00000002_0000000E);
        chk("t1_stall_in_done", 64'(stall_e), 64'd0);
        tick();
        chk("t1_hv_clear", 64'(hilo_valid), 64'd0);

        // DIV -7/2, then hold DONE under M back-pressure
        launch(1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("t2_sign", 64'(div_sign), 64'd1);
        wait_hv("t2_wait");
        chk("t2_hilo", hilo_out, 64'hFFFFFFFF_FFFFFFFD);
        stallM = 1'b1;
        tick(); tick();
        stallM = 1'b0;
        tick(); tick();

        // DIVU 5/0
        sign = 1'b0; a = 32'd5; b = 32'd0; start = 1'b1;
        #1 chk("t3_stall_start", 64'(stall_e), 64'd1);
        tick();
        start = 1'b0;
        #1 chk("t3_stall_zero", 64'(stall_e), 64'd1);
        chk("t3_no_opn", 64'(div_opn_valid), 64'd0);
        tick();
        chk("t3_hv", 64'(hilo_valid), 64'd1);
        chk("t3_hilo", hilo_out, 64'h0);
        chk("t3_stall_done", 64'(stall_e), 64'd0);
        tick();
        chk("t3_hv_clear", 64'(hilo_valid), 64'd0);

        // M stall across div_res_valid
        launch(1'b0, 32'd1000, 32'd3);
        for (int i = 0; i < 80; i++) begin
            if (div_res_valid) break;
            tick();
        end
        chk("t4_resp_seen", 64'(div_res_valid), 64'd1);
        stallM = 1'b1;
        #1 chk("t4_ready_low", 64'(div_res_ready), 64'd0);
        tick(); tick(); tick();
        chk("t4_held", 64'(hilo_valid), 64'd0);
        stallM = 1'b0;
        tick();
        chk("t4_hv", 64'(hilo_valid), 64'd1);
        chk("t4_hilo", hilo_out, 64'h00000001_0000014D);
        tick();
        chk("t4_hv_once", 64'(hilo_valid), 64'd0);

        // Flush 10 cycles into BUSY, then relaunch with fresh operands
        launch(1'b0, 32'd50, 32'd5);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_abort", 64'(div_abort), 64'd1);
        chk("t5_hv", 64'(hilo_valid), 64'd0);
        chk("t5_opn", 64'(div_opn_valid), 64'd0);
        launch(1'b0, 32'd81, 32'd9);
        chk("t5_abort_clear", 64'(div_abort), 64'd0);
        chk("t5_fresh_a", 64'(div_a), 64'd81);
        wait_hv("t5_wait");
        chk("t5_hilo", hilo_out, 64'h00000000_00000009);
        tick();

        // Divider never answers: forced abort
        rsp_en = 1'b0;
        launch(1'b0, 32'd9, 32'd3);
        begin
            int n;
            n = 0;
            for (int i = 0; i < 60; i++) begin
                tick();
                n++;
                if (div_abort) break;
            end
            chk("t6_tmo_cycles", 64'(n), 64'(TIMEOUT));
        end
        chk("t6_terr", 64'(timeout_err), 64'd1);
        chk("t6_hv", 64'(hilo_valid), 64'd1);
        chk("t6_hilo", hilo_out, 64'h0);
        tick();
        chk("t6_abort_pulse", 64'(div_abort), 64'd0);
        chk("t6_sticky", 64'(timeout_err), 64'd1);

        // Asynchronous reset in the middle of BUSY
        launch(1'b0, 32'd9, 32'd3);
        repeat (5) tick();
        #3 rst = 1'b1;
        #1;
        chk("t7_opn", 64'(div_opn_valid), 64'd0);
        chk("t7_terr", 64'(timeout_err), 64'd0);
        chk("t7_stall", 64'(stall_e), 64'd0);
        chk("t7_div_a", 64'(div_a), 64'd0);
        tick();
        rst = 1'b0;
        rsp_en = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequences the multi-cycle radix-2 divider (div_radix2) on behalf of the EX stage.
- Latches operands when a DIV/DIVU reaches EX and drives the divider's valid/ready handshake.
- Generates the EX stall, honours M-stage back-pressure and pipeline flush, and short-circuits divide-by-zero.
- Presents a registered 64-bit {hi,lo} result for exactly one EX-advance so the HI/LO path writes it once.

Parameters:
- TIMEOUT, 48, maximum cycles in BUSY before a forced abort (must be > divider latency, 32+setup).
- CNT_W, 6, width of the busy-cycle counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  EX holds a DIV/DIVU (decoded from alucontrol)
- sign  in  1  1 = DIV (signed), 0 = DIVU
- a  in  32  dividend (rs)
- b  in  32  divisor (rt)
- flush  in  1  D->E flush (flush_endE); kills the in-flight divide
- stallM  in  1  E->M register stalled; result must not be consumed
- div_opn_valid  out  1  to divider opn_valid
- div_a  out  32  latched dividend to divider
- div_b  out  32  latched divisor to divider
- div_sign  out  1  latched sign to divider
- div_abort  out  1  one-cycle pulse, ORed with rst into the divider reset
- div_res_ready  out  1  to divider res_ready
- div_res_valid  in  1  from divider
- div_result  in  64  from divider, {remainder,quotient}
- stall_e  out  1  EX stall (div_stallE)
- hilo_valid  out  1  hilo_out is valid this cycle
- hilo_out  out  64  {hi,lo} result
- timeout_err  out  1  sticky; set on timeout abort, cleared by rst

Behaviour:
- Reset: state=IDLE; all registered outputs 0 (div_opn_valid, div_a/b/sign, div_abort, hilo_valid, hilo_out, timeout_err); counter 0.
- stall_e (combinational) = (IDLE & start & ~flush) | BUSY | ZERO. Never asserted in DONE.
- div_res_ready (combinational) = BUSY & ~stallM.
- IDLE:
  - start & ~flush & b!=0 -> latch a/b/sign; div_opn_valid<=1; counter<=0; go BUSY.
  - start & ~flush & b==0 -> go ZERO; the divider is not started.
- ZERO: hilo_out<=64'h0; hilo_valid<=1; go DONE. Divide-by-zero completes in 2 cycles after start.
- BUSY:
  - div_opn_valid stays 1. Counter increments and saturates.
  - div_res_valid & ~stallM -> hilo_out<=div_result; hilo_valid<=1; div_opn_valid<=0; go DONE.
  - div_res_valid & stallM -> remain in BUSY, hold, stall_e stays 1.
  - Counter reaches TIMEOUT-1 without a result -> div_abort pulse; timeout_err<=1; hilo_out<=0; hilo_valid<=1; go DONE.
- DONE:
  - hilo_valid=1 and stall_e=0, so EX advances.
  - stallM=1 -> hold DONE with hilo_out unchanged.
  - stallM=0 -> hilo_valid<=0; go IDLE. A start in the same cycle belongs to the next instruction; it is sampled from IDLE on the following cycle.
- flush (any state, highest priority after rst):
  - Next state IDLE; div_opn_valid<=0; hilo_valid<=0; counter<=0.
  - div_abort<=1 for one cycle if the state was BUSY; otherwise 0.
  - A flush in IDLE together with start does not launch.
- div_abort: only ever a single-cycle pulse; it clears the next cycle in all cases.
- Operands: a/b may change while BUSY; div_a/div_b are frozen from launch and ignore later input changes.
- Simultaneous events:
  - div_res_valid and flush in the same cycle: the flush wins and the result is discarded.
  - div_res_valid and TIMEOUT in the same cycle: the result wins and there is no error.

Test Plan:
- DIVU a=100, b=7, stallM=0 -> stall_e high from the start cycle until the result; hilo_valid one cycle with hilo_out=={32'd2,32'd14}; then IDLE.
- DIV a=-7 (32'hFFFFFFF9), b=2 -> hilo_out=={32'hFFFFFFFF,32'hFFFFFFFD}; div_sign latched 1.
- DIVU a=5, b=0 -> no div_opn_valid; stall_e for 2 cycles; hilo_out==0; hilo_valid 1 cycle.
- Hold stallM=1 for 3 cycles across div_res_valid -> div_res_ready low, BUSY held; after release, result captured once; hilo_valid exactly 1 cycle while stallM=0.
- Assert flush 10 cycles into BUSY -> div_abort one-cycle pulse; next cycle IDLE, hilo_valid=0; a new start launches with fresh operands.
- Divider model never responds -> at cycle TIMEOUT: div_abort pulse, timeout_err=1 (sticky), hilo_out=0; async rst mid-BUSY clears all outputs immediately.
